rpn_stack_ctrl: RTL and testbench



---
 rtl/rpn_stack_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_ctrl.sv
// RPN token controller driving an external LIFO stack: numbers are pushed, operators pop two
// operands and push the result. Optional multiply opcode enabled by defining RPN_MUL_EN.
module rpn_stack_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tok_valid,
    input  logic                       tok_is_op,
    input  logic [WIDTH-1:0]           tok_data,
    output logic                       tok_ready,
    output logic                       stk_enable,
    output logic                       stk_push_pop,
    output logic [WIDTH-1:0]           stk_data_in,
    input  logic [WIDTH-1:0]           stk_data_out,
    input  logic                       stk_empty,
    input  logic                       stk_full,
    output logic                       res_valid,
    output logic [WIDTH-1:0]           res_data,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       err,
    output logic [1:0]                 err_code,
    input  logic                       err_clr
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DepthMax = DW'(DEPTH);
    localparam logic [DW-1:0] DepthTwo = DW'(2);
    localparam logic [DW-1:0] DepthOne = DW'(1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StPushN = 3'd1;
    localparam logic [2:0] StPopB  = 3'd2;
    localparam logic [2:0] StPopA  = 3'd3;
    localparam logic [2:0] StCapA  = 3'd4;
    localparam logic [2:0] StPushR = 3'd5;
    localparam logic [2:0] StErr   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic             accept;
    logic             new_err;
    logic [1:0]       new_code;
    logic [WIDTH-1:0] alu;

    // A is the deeper operand, arriving on stk_data_out while in CAP_A; B was captured earlier.
    always_comb begin
        case (op_q)
            2'd0:    alu = stk_data_out + b_q;
            2'd1:    alu = stk_data_out - b_q;
            2'd2:    alu = stk_data_out & b_q;
`ifdef RPN_MUL_EN
            default: alu = stk_data_out * b_q;
`else
            default: alu = '0;
`endif
        endcase
    end

    assign tok_ready = (state_q == StIdle) && !err_q && !reset;
    assign accept    = tok_valid && tok_ready;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        op_d     = op_q;
        b_d      = b_q;
        r_d      = r_q;
        depth_d  = depth_q;
        err_d    = err_q;
        code_d   = code_q;
        new_err  = 1'b0;
        new_code = 2'd0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!tok_is_op) begin
                        if ((depth_q < DepthMax) && !stk_full) begin
                            num_d   = tok_data;
                            state_d = StPushN;
                        end else begin
                            new_err  = 1'b1;
                            new_code = 2'd1;
                        end
                    end else if ((depth_q < DepthTwo) || stk_empty) begin
                        new_err  = 1'b1;
                        new_code = 2'd2;
`ifndef RPN_MUL_EN
                    end else if (tok_data[1:0] == 2'd3) begin
                        new_err  = 1'b1;
                        new_code = 2'd3;
`endif
                    end else begin
                        op_d    = tok_data[1:0];
                        state_d = StPopB;
                    end
                end
            end
            StPushN: begin
                depth_d = depth_q + DepthOne;
                state_d = StIdle;
            end
            StPopB: begin
                depth_d = depth_q - DepthOne;
                state_d = StPopA;
            end
            StPopA: begin
                b_d     = stk_data_out;
                depth_d = depth_q - DepthOne;
                state_d = StCapA;
            end
            StCapA: begin
                r_d     = alu;
                state_d = StPushR;
            end
            StPushR: begin
                depth_d = depth_q + DepthOne;
                state_d = StIdle;
            end
            StErr: begin
                if (err_clr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A freshly detected error takes priority over a simultaneous clear.
        if (new_err) begin
            state_d = StErr;
            err_d   = 1'b1;
            code_d  = new_code;
        end else if (err_clr) begin
            err_d  = 1'b0;
            code_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            num_q   <= '0;
            op_q    <= 2'd0;
            b_q     <= '0;
            r_q     <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            op_q    <= op_d;
            b_q     <= b_d;
            r_q     <= r_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Stack commands depend only on state and holding registers; gated so reset never pushes.
    always_comb begin
        stk_enable   = 1'b0;
        stk_push_pop = 1'b0;
        stk_data_in  = '0;
        if (!reset) begin
            case (state_q)
                StPushN: begin
                    stk_enable   = 1'b1;
                    stk_push_pop = 1'b1;
                    stk_data_in  = num_q;
                end
                StPopB, StPopA: begin
                    stk_enable = 1'b1;
                end
                StPushR: begin
                    stk_enable   = 1'b1;
                    stk_push_pop = 1'b1;
                    stk_data_in  = r_q;
                end
                default: ;
            endcase
        end
    end

    assign res_valid = (state_q == StPushR);
    assign res_data  = r_q;
    assign depth     = depth_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Scoreboard bench for rpn_stack_ctrl with a behavioural 8x8 LIFO attached to the stack port.
module tb_rpn_stack_ctrl;
    localparam int W = 8;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         tok_valid, tok_is_op, err_clr;
    logic [W-1:0] tok_data;
    logic         tok_ready, stk_enable, stk_push_pop;
    logic [W-1:0] stk_data_in, stk_data_out;
    logic         stk_empty, stk_full, res_valid, err;
    logic [W-1:0] res_data;
    logic [3:0]   depth;
    logic [1:0]   err_code;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rpn_stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .tok_valid    (tok_valid),
        .tok_is_op    (tok_is_op),
        .tok_data     (tok_data),
        .tok_ready    (tok_ready),
        .stk_enable   (stk_enable),
        .stk_push_pop (stk_push_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_empty    (stk_empty),
        .stk_full     (stk_full),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .depth        (depth),
        .err          (err),
        .err_code     (err_code),
        .err_clr      (err_clr)
    );

    // Stack model: pop at an edge presents the popped word right after that edge.
    logic [W-1:0] mem [D];
    int           sp = 0;
    int           edge_n = 0;
    int           push_edges[$];
    int           pop_edges[$];

    assign stk_empty = (sp <= 0);
    assign stk_full  = (sp >= D);

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (reset) begin
            sp           <= 0;
            stk_data_out <= '0;
        end else if (stk_enable) begin
            if (stk_push_pop) begin
                if (sp < D) mem[sp] <= stk_data_in;
                sp <= sp + 1;
                push_edges.push_back(edge_n + 1);
            end else begin
                if (sp > 0) stk_data_out <= mem[sp-1];
                sp <= sp - 1;
                pop_edges.push_back(edge_n + 1);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [W-1:0] exp_res[$];
    logic [1:0]   exp_err[$];
    logic         err_prev = 1'b0;

    // Monitor: compares each result pulse and each new error against the scoreboard queues.
    always @(negedge clk) begin
        if (!reset && res_valid) begin
            if (exp_res.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL res_unexpected: got res_data 0x%0h with no expected result", res_data);
            end else begin
                check("res_data", res_data, exp_res.pop_front());
            end
        end
        if (!reset && err && !err_prev) begin
            if (exp_err.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL err_unexpected: got err_code %0d with no expected error", err_code);
            end else begin
                check("err_code_mon", err_code, exp_err.pop_front());
            end
        end
        err_prev <= err;
    end

    int t_acc;

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tok_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got tok_ready 0 expected 1 within 40 cycles");
        end
    endtask

    task automatic send(input bit is_op, input logic [W-1:0] d);
        wait_ready();
        tok_valid = 1'b1;
        tok_is_op = is_op;
        tok_data  = d;
        @(posedge clk);
        #1 t_acc = edge_n;
        @(negedge clk);
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = '0;
        err_clr   = 1'b0;

        // Reset values
        @(negedge clk);
        check("ready_in_reset", tok_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", tok_ready, 1);
        check("rst_enable", stk_enable, 0);
        check("rst_push_pop", stk_push_pop, 0);
        check("rst_data_in", stk_data_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_depth", depth, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);

        // 5 + 3 with cycle-exact timing
        send(0, 8'd5);
        send(0, 8'd3);
        wait_ready();
        pop_edges.delete();
        push_edges.delete();
        exp_res.push_back(8'd8);
        send(1, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("ready_busy_T3", tok_ready, 0);
        @(posedge clk);
        #1;
        check("ready_back_T4", tok_ready, 1);
        check("pop_count", pop_edges.size(), 2);
        if (pop_edges.size() == 2) begin
            check("pop1_edge", pop_edges[0], t_acc + 1);
            check("pop2_edge", pop_edges[1], t_acc + 2);
        end
        check("push_count", push_edges.size(), 1);
        if (push_edges.size() == 1) check("push_edge", push_edges[0], t_acc + 4);
        check("add_depth", depth, 1);
        check("add_stack", mem[0], 8'd8);
        @(negedge clk);

        // 2 - 7 wraps; then 0xF0 & 0xFB
        send(0, 8'd2);
        send(0, 8'd7);
        exp_res.push_back(8'hFB);
        send(1, 8'd1);
        send(0, 8'hF0);
        exp_res.push_back(8'hF0);
        send(1, 8'd2);
        wait_ready();
        check("sub_and_depth", depth, 2);

        // Nine pushes: the ninth overflows without touching the stack
        do_reset();
        for (int i = 1; i <= 8; i++) send(0, W'(i));
        wait_ready();
        push_edges.delete();
        exp_err.push_back(2'd1);
        send(0, 8'd9);
        check("ovf_err_T1", err, 1);
        repeat (2) @(negedge clk);
        check("ovf_code", err_code, 1);
        check("ovf_depth", depth, 8);
        check("ovf_no_push", push_edges.size(), 0);
        check("ovf_ready", tok_ready, 0);
        clear_err();
        check("clr_ready", tok_ready, 1);
        check("clr_err", err, 0);
        // Operator at full depth: net -1
        exp_res.push_back(8'd15);
        send(1, 8'd0);
        wait_ready();
        check("full_op_depth", depth, 7);
        check("full_op_stack", mem[6], 8'd15);

        // Underflow with one entry
        do_reset();
        send(0, 8'd4);
        wait_ready();
        pop_edges.delete();
        exp_err.push_back(2'd2);
        send(1, 8'd0);
        repeat (3) @(negedge clk);
        check("udf_code", err_code, 2);
        check("udf_no_pop", pop_edges.size(), 0);
        check("udf_depth", depth, 1);
        clear_err();

        // Opcode 3
        do_reset();
        send(0, 8'd6);
        send(0, 8'd7);
        wait_ready();
        pop_edges.delete();
`ifdef RPN_MUL_EN
        exp_res.push_back(8'd42);
        send(1, 8'd3);
        wait_ready();
        check("mul_depth", depth, 1);
`else
        exp_err.push_back(2'd3);
        send(1, 8'd3);
        repeat (3) @(negedge clk);
        check("op3_code", err_code, 3);
        check("op3_no_pop", pop_edges.size(), 0);
        check("op3_depth", depth, 2);
        clear_err();
`endif

        // Reset while in CAP_A aborts the operator
        do_reset();
        send(0, 8'd1);
        send(0, 8'd2);
        wait_ready();
        push_edges.delete();
        send(1, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_depth", depth, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_enable", stk_enable, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_push", push_edges.size(), 0);
        check("abort_ready", tok_ready, 1);

        check("res_drained", exp_res.size(), 0);
        check("err_drained", exp_err.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
